sar_sequencer: RTL and testbench
================================

Name: sar_sequencer

Overview:
- Successive-approximation controller for the multi-channel ADC front end; sits directly upstream of the capture/writer stage.
- Drives the shared trial DAC code, the one-hot bit-under-test strobe and the one-hot channel select, which the writer consumes.
- Samples the shared comparator and converts every enabled channel in ascending order per start request.
- Emits each finished code with its channel index.

Parameters:
- NBITS, 10, conversion resolution (bits per channel).
- NCH, 8, number of analog channels.
- SETTLE, 2, DAC/comparator settling cycles before each decision; legal range 1..15.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a scan; honoured only in IDLE.
- ch_mask  in  NCH  channel enables; latched on accepted start.
- abort  in  1  synchronous abort; terminates the scan, no done pulse.
- comp  in  1  comparator output; 1 = input >= DAC code (keep bit).
- D  out  NBITS  trial DAC code.
- bitctrl  out  NBITS  one-hot bit under test; MSB first, shifts right.
- ADCctrl  out  NCH  one-hot channel select; zero when idle.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- result  out  NBITS  final code; valid with result_valid, held until the next result.
- result_ch  out  $clog2(NCH)  channel index of result.
- result_valid  out  1  one-cycle pulse per finished channel.
- done  out  1  one-cycle pulse at scan end.

Behaviour:
- Reset: all outputs 0, state IDLE, latched mask 0; takes effect immediately, including mid-conversion.
- States: IDLE, SELECT, SETTLE, DECIDE, NEXTCH, DONE; all outputs registered.
- IDLE, start=1, mask!=0: latch mask; go to SELECT on the lowest set channel.
- IDLE, start=1, mask==0: go to DONE (done pulses 1 cycle after start, no conversion).
- SELECT (1 cycle): ADCctrl=1<<ch; D=1<<(NBITS-1); bitctrl=1<<(NBITS-1); settle counter=SETTLE; next state SETTLE.
- SETTLE: decrement the counter; when it reaches 1, go to DECIDE. Total SETTLE cycles spent here.
- DECIDE (1 cycle): sample comp.
  - comp=0: clear D at the bitctrl position.
  - If bitctrl[0]=1: go to NEXTCH, bitctrl stays 1.
  - Otherwise: bitctrl>>=1; set D at the new position; reload counter; go to SETTLE.
- Per-channel latency: 1 + NBITS*(SETTLE+1) cycles, SELECT through last DECIDE (31 at defaults).
- NEXTCH (1 cycle): result=D; result_ch=ch; result_valid=1; bitctrl=0; D=0.
  - Next: SELECT on the next higher enabled channel, or DONE if none.
  - No wrap-around; bits below the current channel are ignored.
- DONE (1 cycle): done=1; ADCctrl=0; next state IDLE; busy low the following cycle.
- start while not in IDLE is ignored; ch_mask changes mid-scan are ignored.
- abort=1 in any non-IDLE state: next cycle IDLE with D/bitctrl/ADCctrl/busy=0; no result_valid or done for the partial channel. Earlier results stay on result/result_ch.
- abort and start in the same IDLE cycle: abort wins, start dropped.
- comp is sampled only in DECIDE; its value in other states has no effect.
- At most one bitctrl bit and one ADCctrl bit set at any time (assertion).

Test Plan:
- Single channel: mask=0x02; comparator model with Vin code 0x32B -> D trials 0x200,0x300,0x380→0x300,...; result=0x32B, result_ch=1; result_valid 31 cycles after SELECT; done 1 cycle later.
- Two channels: mask=0x12; ch1=0x32B, ch4=0x303 -> two result_valid pulses 32 cycles apart, ch1 first; ADCctrl goes 0x02 then 0x10; one done pulse.
- Extremes: Vin 0x3FF -> result 0x3FF; Vin 0x000 -> result 0x000; bitctrl visits all 10 positions each time; SETTLE=1 build -> per-channel latency 21.
- Abort: mask=0xFF, abort during ch2 bit 5 -> next cycle all outputs 0 except held ch0/ch1 results; no done; subsequent start runs cleanly.
- Async reset mid-conversion -> outputs 0 within the same cycle without a clock edge; start after release -> normal scan.
- Edge requests: start with mask=0 -> done 1 cycle later, busy 1 cycle only; start pulses while busy -> ignored, result count unchanged.

Source files
------------

// File: rtl/sar_sequencer.sv
// -----------------------------------------------------------------------------
// sar_sequencer
//
// Successive-approximation controller for the multi-channel ADC front end.
// On an accepted start it converts every enabled channel in ascending order.
// For each channel it walks one bit at a time, MSB first, through a trial DAC
// code, and uses the shared comparator to decide whether to keep each bit.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   start        single-cycle scan request, honoured only when idle
//   ch_mask      channel enables, latched when a start is accepted
//   abort        synchronous abort; drops the scan with no done pulse
//   comp         comparator output, 1 = input >= trial code (keep bit)
//   D            trial DAC code
//   bitctrl      one-hot bit under test, MSB first
//   ADCctrl      one-hot channel select, zero when idle
//   busy         high from the cycle after an accepted start until idle again
//   result       finished code, held until the next result
//   result_ch    channel index of result
//   result_valid one-cycle pulse per finished channel
//   done         one-cycle pulse at the end of a scan
//
// All outputs are registered and take the value that belongs to the state
// being entered, so each state's outputs are visible during that state.
// -----------------------------------------------------------------------------
module sar_sequencer #(
    parameter int NBITS  = 10,
    parameter int NCH    = 8,
    parameter int SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NCH-1:0]         ch_mask,
    input  logic                   abort,
    input  logic                   comp,
    output logic [NBITS-1:0]       D,
    output logic [NBITS-1:0]       bitctrl,
    output logic [NCH-1:0]         ADCctrl,
    output logic                   busy,
    output logic [NBITS-1:0]       result,
    output logic [$clog2(NCH)-1:0] result_ch,
    output logic                   result_valid,
    output logic                   done
);

    localparam int               CHW       = $clog2(NCH);
    localparam logic [NBITS-1:0] MSB       = {1'b1, {(NBITS-1){1'b0}}};
    localparam logic [3:0]       SETTLE_LD = 4'(SETTLE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SETTLE,
        S_DECIDE,
        S_NEXTCH,
        S_DONE
    } state_t;

    state_t         state;
    logic [NCH-1:0] mask;
    logic [CHW-1:0] ch;
    logic [3:0]     cnt;

    // Lowest set channel at or above lo; MSB of the return value flags a hit.
    function automatic logic [CHW:0] find_ch(input logic [NCH-1:0] m, input int lo);
        logic [CHW:0] hit;
        hit = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (i >= lo && m[i]) begin
                hit = {1'b1, CHW'(i)};
            end
        end
        return hit;
    endfunction

    function automatic logic [NCH-1:0] ch_onehot(input logic [CHW-1:0] idx);
        logic [NCH-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    logic [CHW:0]     first_hit;
    logic [CHW:0]     next_hit;
    logic [NBITS-1:0] kept;
    logic [NBITS-1:0] next_bit;

    assign first_hit = find_ch(ch_mask, 0);
    // Search strictly above the current channel: the scan never wraps.
    assign next_hit  = find_ch(mask, int'(ch) + 1);
    // Trial code after the decision: drop the bit under test if comp says so.
    assign kept      = comp ? D : (D & ~bitctrl);
    assign next_bit  = bitctrl >> 1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            mask         <= '0;
            ch           <= '0;
            cnt          <= '0;
            D            <= '0;
            bitctrl      <= '0;
            ADCctrl      <= '0;
            busy         <= 1'b0;
            result       <= '0;
            result_ch    <= '0;
            result_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            done         <= 1'b0;

            if (abort) begin
                // Abort also wins over a start seen in the same idle cycle.
                state   <= S_IDLE;
                D       <= '0;
                bitctrl <= '0;
                ADCctrl <= '0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            busy <= 1'b1;
                            mask <= ch_mask;
                            if (first_hit[CHW]) begin
                                state   <= S_SELECT;
                                ch      <= first_hit[CHW-1:0];
                                ADCctrl <= ch_onehot(first_hit[CHW-1:0]);
                                D       <= MSB;
                                bitctrl <= MSB;
                                cnt     <= SETTLE_LD;
                            end else begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end
                        end
                    end

                    S_SELECT: begin
                        state <= S_SETTLE;
                    end

                    // cnt was loaded with SETTLE on entry, so this state lasts
                    // exactly SETTLE cycles.
                    S_SETTLE: begin
                        if (cnt == 4'd1) begin
                            state <= S_DECIDE;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end

                    S_DECIDE: begin
                        if (bitctrl[0]) begin
                            state        <= S_NEXTCH;
                            result       <= kept;
                            result_ch    <= ch;
                            result_valid <= 1'b1;
                            bitctrl      <= '0;
                            D            <= '0;
                        end else begin
                            state   <= S_SETTLE;
                            bitctrl <= next_bit;
                            D       <= kept | next_bit;
                            cnt     <= SETTLE_LD;
                        end
                    end

                    S_NEXTCH: begin
                        if (next_hit[CHW]) begin
                            state   <= S_SELECT;
                            ch      <= next_hit[CHW-1:0];
                            ADCctrl <= ch_onehot(next_hit[CHW-1:0]);
                            D       <= MSB;
                            bitctrl <= MSB;
                            cnt     <= SETTLE_LD;
                        end else begin
                            state   <= S_DONE;
                            ADCctrl <= '0;
                            done    <= 1'b1;
                        end
                    end

                    S_DONE: begin
                        state   <= S_IDLE;
                        ADCctrl <= '0;
                        busy    <= 1'b0;
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    a_onehot_ctrl: assert property (@(posedge clk) disable iff (reset)
        $onehot0(bitctrl) && $onehot0(ADCctrl));

endmodule

// File: tb/tb_sar_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sar_sequencer
//
// Scoreboard bench for sar_sequencer. An ideal comparator is built from a
// per-channel input code, so every conversion must return exactly that code.
// When a scan is issued, the expected results (code, channel, arrival cycle)
// and the expected done cycle are queued. A negedge monitor pops these entries
// and compares them whenever the DUT pulses result_valid or done. The monitor
// also checks every trial code against the SAR rule: the decided upper bits
// match the input, the bit under test is set, and the lower bits are clear.
// A second instance built with SETTLE=1 checks the shorter latency.
// -----------------------------------------------------------------------------
module tb_sar_sequencer;

    localparam int NBITS  = 10;
    localparam int NCH    = 8;
    localparam int SETTLE = 2;
    localparam int CHW    = $clog2(NCH);
    localparam int L      = 1 + NBITS * (SETTLE + 1);
    localparam int L1     = 1 + NBITS * (1 + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [NCH-1:0]   ch_mask = '0;
    logic             comp;
    logic [NBITS-1:0] D, bitctrl, result;
    logic [NCH-1:0]   ADCctrl;
    logic             busy, result_valid, done;
    logic [CHW-1:0]   result_ch;

    logic             start1 = 1'b0;
    logic             abort1 = 1'b0;
    logic [NCH-1:0]   ch_mask1 = '0;
    logic             comp1;
    logic [NBITS-1:0] D1, bitctrl1, result1;
    logic [NCH-1:0]   ADCctrl1;
    logic             busy1, result_valid1, done1;
    logic [CHW-1:0]   result_ch1;

    sar_sequencer #(.NBITS(NBITS), .NCH(NCH), .SETTLE(SETTLE)) dut (
        .clk(clk), .reset(reset), .start(start), .ch_mask(ch_mask),
        .abort(abort), .comp(comp), .D(D), .bitctrl(bitctrl),
        .ADCctrl(ADCctrl), .busy(busy), .result(result),
        .result_ch(result_ch), .result_valid(result_valid), .done(done)
    );

    sar_sequencer #(.NBITS(NBITS), .NCH(NCH), .SETTLE(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .ch_mask(ch_mask1),
        .abort(abort1), .comp(comp1), .D(D1), .bitctrl(bitctrl1),
        .ADCctrl(ADCctrl1), .busy(busy1), .result(result1),
        .result_ch(result_ch1), .result_valid(result_valid1), .done(done1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- analog model ----------------
    logic [NBITS-1:0] vin [NCH];
    logic [NBITS-1:0] vin_sel;
    logic [NBITS-1:0] vin1 = '0;
    logic             noise = 1'b0;

    always_comb begin
        vin_sel = '0;
        for (int i = 0; i < NCH; i++) if (ADCctrl[i]) vin_sel = vin[i];
    end

    // When no bit is under test the comparator output must not matter.
    assign comp  = (bitctrl != '0) ? (vin_sel >= D) : noise;
    assign comp1 = (bitctrl1 != '0) ? (vin1 >= D1) : noise;

    always @(negedge clk) noise <= 1'($urandom_range(0, 1));

    function automatic logic [NBITS-1:0] trial_code(input logic [NBITS-1:0] v,
                                                    input logic [NBITS-1:0] pos);
        logic [NBITS-1:0] above;
        above = ~((pos << 1) - NBITS'(1));
        return (v & above) | pos;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [NBITS-1:0] code;
        int               ch;
        int               cycle;
    } exp_t;

    exp_t             exp_q[$];
    int               done_q[$];
    exp_t             mon_e;
    int               mon_d;
    logic [NBITS-1:0] visited = '0;

    always @(negedge clk) begin
        if (reset) begin
            visited = '0;
        end else begin
            if (bitctrl != '0) begin
                visited = visited | bitctrl;
                check("trial_code", 32'(D), 32'(trial_code(vin_sel, bitctrl)));
            end
            if (result_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result_valid", 32'(result_valid), 32'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("result_code", 32'(result), 32'(mon_e.code));
                    check("result_ch", 32'(result_ch), 32'(mon_e.ch));
                    check("result_cycle", 32'(cyc), 32'(mon_e.cycle));
                    check("bits_visited", 32'(visited), 32'({NBITS{1'b1}}));
                end
                visited = '0;
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'(0));
                end else begin
                    mon_d = done_q.pop_front();
                    check("done_cycle", 32'(cyc), 32'(mon_d));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Issue a start; channels below stop_ch are expected to finish, and a done
    // pulse is expected only when the scan is allowed to run to the end.
    task automatic start_scan(input logic [NCH-1:0] m, input int stop_ch);
        int e;
        int k;
        @(negedge clk);
        start   = 1'b1;
        ch_mask = m;
        e       = cyc + 1;
        k       = 0;
        for (int c = 0; c < NCH; c++) begin
            if (m[c]) begin
                if (c < stop_ch) exp_q.push_back('{code: vin[c], ch: c, cycle: e + L + (L + 1) * k});
                k++;
            end
        end
        if (stop_ch >= NCH) done_q.push_back(e + (L + 1) * k);
        @(negedge clk);
        start   = 1'b0;
        ch_mask = NCH'($urandom);
    endtask

    // Run to the end of the scan while pulsing start and scrambling ch_mask.
    task automatic finish_scan();
        int t;
        t = 0;
        while (busy && t < 3000) begin
            start   = ($urandom_range(0, 7) == 0);
            ch_mask = NCH'($urandom);
            @(negedge clk);
            t++;
        end
        start = 1'b0;
        check("scan_completes", 32'(busy), 32'(0));
        repeat (3) @(negedge clk);
        check("results_drained", 32'(exp_q.size()), 32'(0));
        check("done_drained", 32'(done_q.size()), 32'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_D"}, 32'(D), 32'(0));
        check({tag, "_bitctrl"}, 32'(bitctrl), 32'(0));
        check({tag, "_ADCctrl"}, 32'(ADCctrl), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_result_valid"}, 32'(result_valid), 32'(0));
        check({tag, "_done"}, 32'(done), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int t;
        int e1;
        logic [NCH-1:0] m;

        for (int c = 0; c < NCH; c++) vin[c] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        check("reset_result", 32'(result), 32'(0));
        check("reset_result_ch", 32'(result_ch), 32'(0));
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single channel
        vin[1] = 10'h32B;
        start_scan(8'h02, NCH);
        finish_scan();
        check("single_result_held", 32'(result), 32'h32B);

        // Two channels
        vin[1] = 10'h32B;
        vin[4] = 10'h303;
        start_scan(8'h12, NCH);
        finish_scan();

        // Extremes
        vin[3] = 10'h3FF;
        start_scan(8'h08, NCH);
        finish_scan();
        vin[5] = 10'h000;
        start_scan(8'h20, NCH);
        finish_scan();

        // Empty mask: done one cycle after start, busy for one cycle
        start_scan(8'h00, NCH);
        check("zero_mask_busy_on", 32'(busy), 32'(1));
        check("zero_mask_ADCctrl", 32'(ADCctrl), 32'(0));
        @(negedge clk);
        check("zero_mask_busy_off", 32'(busy), 32'(0));
        repeat (2) @(negedge clk);
        check("zero_mask_done_seen", 32'(done_q.size()), 32'(0));

        // Abort and start together in idle: abort wins
        @(negedge clk);
        start   = 1'b1;
        abort   = 1'b1;
        ch_mask = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_beats_start_busy", 32'(busy), 32'(0));
        check("abort_beats_start_ADCctrl", 32'(ADCctrl), 32'(0));

        // Abort during channel 2, bit 5
        for (int c = 0; c < NCH; c++) vin[c] = NBITS'($urandom);
        start_scan(8'hFF, 2);
        t = 0;
        while (!(ADCctrl == 8'h04 && bitctrl == 10'h020) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("abort_point_reached", 32'(t < 2000), 32'(1));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_all_zero("abort");
        check("abort_result_held", 32'(result), 32'(vin[1]));
        check("abort_result_ch_held", 32'(result_ch), 32'(1));
        repeat (40) @(negedge clk);
        check("abort_stays_idle", 32'(busy), 32'(0));
        check("abort_no_stray_results", 32'(exp_q.size()), 32'(0));

        // Clean scan after abort
        start_scan(8'h81, NCH);
        finish_scan();

        // Randomized scans
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < NCH; c++) vin[c] = NBITS'($urandom);
            m = '0;
            while (m == '0) m = NCH'($urandom);
            start_scan(m, NCH);
            finish_scan();
        end

        // Asynchronous reset mid-conversion
        for (int c = 0; c < NCH; c++) vin[c] = NBITS'($urandom);
        start_scan(8'h0F, 1);
        repeat (45) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        check("async_reset_result", 32'(result), 32'(0));
        check("async_reset_pending", 32'(exp_q.size() + done_q.size()), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        start_scan(8'h24, NCH);
        finish_scan();

        // SETTLE=1 build: per-channel latency 21
        vin1 = NBITS'($urandom);
        @(negedge clk);
        start1   = 1'b1;
        ch_mask1 = 8'h40;
        e1       = cyc + 1;
        @(negedge clk);
        start1 = 1'b0;
        t = 0;
        while (!result_valid1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("settle1_latency", 32'(cyc - e1), 32'(L1));
        check("settle1_code", 32'(result1), 32'(vin1));
        check("settle1_ch", 32'(result_ch1), 32'(6));
        @(negedge clk);
        check("settle1_done", 32'(done1), 32'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
